fcp_rx_crc_chk: RTL and testbench

- Receive-side checker that sits directly upstream of the 32-bit FCP CRC-8 engine (poly 1+x^3+x^4+x^5+x^8, synchronous clear, init 0x00).
- Accepts the de-serialised FCP byte stream and packs payload bytes into 32-bit words.
- Drives the engine's data, enable and clear inputs, then compares the engine's result against the trailing received CRC byte.
- Reports one pass/fail pulse per packet to the protocol FSM.

---
 rtl/fcp_pkg.sv | 7 +
 rtl/fcp_byte_packer.sv | 50 +++++
 rtl/fcp_rx_crc_chk.sv | 90 +++++++++
 tb/tb_fcp_rx_crc_chk.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fcp_pkg.sv
// fcp_pkg: shared FCP receive-check types and constants
package fcp_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, WAIT, DONE, DRAIN} fcp_state_e;
  localparam logic [7:0] FCP_CRC_INIT = 8'h00;
  localparam int FCP_WORD_BYTES = 4;
  localparam int FCP_MAX_BYTES = 16;
endpackage

// File: rtl/fcp_byte_packer.sv
// fcp_byte_packer: packs bytes little-endian into 32-bit words, zero-padding a partial word on flush
module fcp_byte_packer
  import fcp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        flush,
  input  logic        clr,
  output logic [31:0] word,
  output logic        word_valid
);
  localparam int IW = $clog2(FCP_WORD_BYTES);
  logic [31:0]   acc;
  logic [31:0]   acc_nx;
  logic [IW-1:0] idx;
  logic          full;
  assign full = idx == IW'(FCP_WORD_BYTES - 1);
  // Insert the incoming byte at its lane; unfilled lanes stay zero for padding
  always_comb begin
    acc_nx = acc;
    acc_nx[idx*8 +: 8] = in_data;
  end
  // Accumulate bytes; emit a word pulse on the last lane or on flush of a partial word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      idx        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      acc        <= '0;
      idx        <= '0;
      word_valid <= 1'b0;
    end else if (in_valid) begin
      word_valid <= full;
      idx        <= full ? '0 : idx + 1'b1;
      acc        <= full ? '0 : acc_nx;
      if (full) word <= acc_nx;
    end else if (flush && idx != '0) begin
      word       <= acc;
      word_valid <= 1'b1;
      acc        <= '0;
      idx        <= '0;
    end else begin
      word_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fcp_rx_crc_chk.sv
// fcp_rx_crc_chk: feeds received FCP payload to the CRC-8 engine and checks the trailing CRC byte
module fcp_rx_crc_chk
  import fcp_pkg::*;
#(
  parameter int MAX_BYTES = FCP_MAX_BYTES,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic [31:0]      crc_data_o,
  output logic             crc_en_o,
  output logic             crc_clr_o,
  input  logic [7:0]       crc_in,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic             pkt_len_err,
  output logic [CNT_W-1:0] pkt_len
);
  fcp_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [7:0]       rx_crc;
  logic             pay, last, at_max, take, err;
  assign pay    = s_valid & s_ready & ~s_last;
  assign last   = s_valid & s_ready & s_last;
  assign at_max = cnt == CNT_W'(MAX_BYTES);
  assign take   = pay & (state == IDLE | (state == COLLECT & ~at_max));
  assign err    = (cnt == '0) | ovf;
  fcp_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (take),
    .in_data    (s_data),
    .flush      (last),
    .clr        (state == DONE),
    .word       (crc_data_o),
    .word_valid (crc_en_o)
  );
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // Next state, ready and engine-clear/done strobes
  always_comb begin
    state_nx  = state;
    s_ready   = state == IDLE || state == COLLECT || state == DRAIN;
    crc_clr_o = (state == IDLE && !pay) || state == DONE;
    pkt_done  = state == DONE;
    case (state)
      IDLE:    if (s_valid) state_nx = s_last ? FLUSH : COLLECT;
      COLLECT: if (s_valid) state_nx = s_last ? FLUSH : at_max ? DRAIN : COLLECT;
      DRAIN:   if (s_valid && s_last) state_nx = FLUSH;
      FLUSH:   state_nx = WAIT;
      WAIT:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Byte count, overflow flag, stored CRC byte and the registered verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      ovf         <= 1'b0;
      rx_crc      <= '0;
      pkt_ok      <= 1'b0;
      pkt_len_err <= 1'b0;
      pkt_len     <= '0;
    end else begin
      if (state == DONE) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (take) begin
        cnt <= cnt + 1'b1;
      end else if (pay && state == COLLECT) begin
        ovf <= 1'b1;
      end
      if (last) rx_crc <= s_data;
      if (state == WAIT) begin
        pkt_ok      <= (crc_in == rx_crc) & ~err;
        pkt_len_err <= err;
        pkt_len     <= cnt;
      end
    end
  end
endmodule

// File: tb/tb_fcp_rx_crc_chk.sv
// tb_fcp_rx_crc_chk: table-driven check of the receive CRC checker against a behavioural CRC-8 engine
module tb_fcp_rx_crc_chk;
  localparam int MB = 8;
  localparam int CW = 8;

  typedef struct {
    int          n;
    logic [95:0] d;
    logic [7:0]  crc;
    logic        ok;
    logic        err;
    int          len;
    int          en;
    logic        fwv;
    logic [31:0] fw;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, s_valid, s_last, s_ready;
  logic [7:0]    s_data;
  logic [31:0]   crc_data_o;
  logic          crc_en_o, crc_clr_o, pkt_done, pkt_ok, pkt_len_err;
  logic [7:0]    crc_in = 8'h00;
  logic [CW-1:0] pkt_len;
  int            n_vec = 0, n_err = 0, en_cnt = 0, done_cnt = 0;
  vec_t          vt[8];

  fcp_rx_crc_chk #(.MAX_BYTES(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .crc_data_o(crc_data_o), .crc_en_o(crc_en_o), .crc_clr_o(crc_clr_o),
    .crc_in(crc_in), .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_len_err(pkt_len_err),
    .pkt_len(pkt_len)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] step(input logic [7:0] c, input logic [31:0] d);
    logic [7:0] r = c;
    for (int i = 31; i >= 0; i--) r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h39 : 8'h00);
    return r;
  endfunction

  function automatic logic [7:0] crc_ref(input logic [95:0] d, input int n);
    logic [7:0] c = 8'h00;
    for (int w = 0; w < (n + 3) / 4; w++) c = step(c, d[w*32 +: 32]);
    return c;
  endfunction

  function automatic vec_t mk(input int n, input logic [95:0] d, input logic [7:0] crc,
                              input logic ok, input logic err, input int len, input int en,
                              input logic fwv, input logic [31:0] fw);
    vec_t v;
    v.n = n; v.d = d; v.crc = crc; v.ok = ok; v.err = err;
    v.len = len; v.en = en; v.fwv = fwv; v.fw = fw;
    return v;
  endfunction

  always @(posedge clk) crc_in <= crc_clr_o ? 8'h00 : crc_en_o ? step(crc_in, crc_data_o) : crc_in;

  always @(negedge clk) begin
    if (crc_en_o) en_cnt++;
    if (pkt_done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic finish_pkt(input string tag, input vec_t v, input int e0);
    int k = 0;
    logic fen = 1'b0, ok = 1'b0, err = 1'b0, clr = 1'b0;
    logic [31:0] fd = '0;
    logic [CW-1:0] len = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin fen = crc_en_o; fd = crc_data_o; end
      if (pkt_done) begin
        k = i; ok = pkt_ok; err = pkt_len_err; len = pkt_len; clr = crc_clr_o;
        break;
      end
    end
    @(negedge clk); #1;
    chk({tag, " done_latency"}, k, 3);
    chk({tag, " pkt_ok"}, ok, v.ok);
    chk({tag, " pkt_len_err"}, err, v.err);
    if (v.len >= 0) chk({tag, " pkt_len"}, len, v.len);
    chk({tag, " en_pulses"}, en_cnt - e0, v.en);
    chk({tag, " flush_en"}, fen, v.fwv);
    if (v.fwv) chk({tag, " flush_word"}, fd, v.fw);
    chk({tag, " clr_in_done"}, clr, 1'b1);
    chk({tag, " crc_in_after"}, crc_in, 8'h00);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int e0 = en_cnt;
    for (int i = 0; i < v.n; i++) put(v.d[i*8 +: 8], 1'b0);
    put(v.crc, 1'b1);
    finish_pkt(tag, v, e0);
  endtask

  initial begin
    vec_t v;
    int e0, d0;
    vt[0] = mk(4, 96'h0, 8'h00, 1, 0, 4, 1, 0, 0);
    vt[1] = mk(3, 96'h332211, 8'hAB, crc_ref(96'h332211, 3) == 8'hAB, 0, 3, 1, 1, 32'h00332211);
    vt[2] = mk(4, 96'h0, 8'h01, 0, 0, 4, 1, 0, 0);
    vt[3] = mk(0, 96'h0, 8'h00, 0, 1, 0, 0, 0, 0);
    vt[4] = mk(11, {11{8'h55}}, 8'h00, 0, 1, -1, 2, 0, 0);
    vt[5] = mk(8, 96'h0807060504030201, crc_ref(96'h0807060504030201, 8), 1, 0, 8, 2, 0, 0);
    vt[6] = mk(5, 96'hE5D4C3B2A1, crc_ref(96'hE5D4C3B2A1, 5), 1, 0, 5, 2, 1, 32'h000000E5);
    vt[7] = mk(7, 96'h16151413121110, crc_ref(96'h16151413121110, 7) ^ 8'h01, 0, 0, 7, 2, 1, 32'h00161514);

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst s_ready", s_ready, 1'b1);
    chk("rst crc_clr", crc_clr_o, 1'b1);
    chk("rst crc_en", crc_en_o, 1'b0);
    chk("rst crc_data", crc_data_o, 32'h0);
    chk("rst pkt_done", pkt_done, 1'b0);
    chk("rst pkt_ok", pkt_ok, 1'b0);
    chk("rst pkt_len_err", pkt_len_err, 1'b0);
    chk("rst pkt_len", pkt_len, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // 4th byte of a word produces the engine strobe in the next cycle; an input gap holds state
    e0 = en_cnt;
    put(8'hDE, 0); put(8'hAD, 0);
    repeat (3) @(posedge clk);
    #1;
    put(8'hBE, 0);
    @(negedge clk);
    chk("word3 no_en", crc_en_o, 1'b0);
    put(8'hEF, 0);
    @(negedge clk);
    chk("word4 en", crc_en_o, 1'b1);
    chk("word4 data", crc_data_o, 32'hEFBEADDE);
    v = mk(4, 96'hEFBEADDE, step(8'h00, 32'hEFBEADDE), 1, 0, 4, 1, 0, 0);
    put(v.crc, 1);
    finish_pkt("gap", v, e0);

    // Overflow: ready stays high while excess bytes are drained
    e0 = en_cnt;
    for (int i = 0; i < 9; i++) put(8'h33, 0);
    @(negedge clk);
    chk("drain ready0", s_ready, 1'b1);
    put(8'h44, 0);
    @(negedge clk);
    chk("drain ready1", s_ready, 1'b1);
    put(8'h45, 0);
    @(negedge clk);
    chk("drain ready2", s_ready, 1'b1);
    put(8'h00, 1);
    finish_pkt("drain", mk(11, 96'h0, 8'h00, 0, 1, -1, 2, 0, 0), e0);

    // Reset mid-packet aborts silently; the next packet is checked normally
    for (int i = 0; i < 5; i++) put(8'h00, 0);
    d0 = done_cnt;
    rst_n = 1'b0;
    #2;
    chk("abort ready", s_ready, 1'b1);
    chk("abort clr", crc_clr_o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort no_done", done_cnt - d0, 0);
    run_vec("post_abort", vt[0]);
    chk("post_abort done_count", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
